// File: rtl/mcu_pkg.sv
// -----------------------------------------------------------------------------
// mcu_pkg
// Shared constants and types for the MCU front end.
//   PROG_AW       : program address width (fetch PC width)
//   INST_DW       : instruction width
//   FIFO_DEPTH    : default prefetch queue depth (power of two, >= 2)
//   pf_state_e    : prefetch FSM state encoding (IDLE, FETCH, FULL, FLUSH)
// -----------------------------------------------------------------------------
package mcu_pkg;

  localparam int PROG_AW    = 5;
  localparam int INST_DW    = 8;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // held in reset, leaves on the first edge after release
    FETCH = 2'd1,  // issuing ROM reads while queue slots are free
    FULL  = 2'd2,  // every slot is either queued or in flight
    FLUSH = 2'd3   // one dead cycle after a redirect
  } pf_state_e;

endpackage

// File: rtl/inst_prefetch_if.sv
// -----------------------------------------------------------------------------
// inst_prefetch_if
// Bus bundle around the instruction prefetch stage.
//   ROM side        : prom_rd, prom_addr (to ROM), prom_data (from ROM, one
//                     cycle after prom_rd is sampled)
//   Controller side : ld, redirect, redirect_addr (to prefetch),
//                     inst_valid, inst_out, inst_pc (from prefetch)
// Modports:
//   master : the prefetch stage itself
//   slave  : the surrounding ROM + pipeline controller
// -----------------------------------------------------------------------------
interface inst_prefetch_if #(
  parameter int AW = mcu_pkg::PROG_AW,
  parameter int DW = mcu_pkg::INST_DW
);

  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          prom_rd;
  logic [AW-1:0] prom_addr;
  logic [DW-1:0] prom_data;
  logic          ld;
  logic          inst_valid;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;

  modport master (
    input  redirect, redirect_addr, prom_data, ld,
    output prom_rd, prom_addr, inst_valid, inst_out, inst_pc
  );

  modport slave (
    output redirect, redirect_addr, prom_data, ld,
    input  prom_rd, prom_addr, inst_valid, inst_out, inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous instruction queue for the prefetch stage.
//   clk, reset      : clock, asynchronous active-high reset
//   flush_i         : drop all entries (pointers and count to zero)
//   push_i          : write push_data_i (and push_pc_i) at the tail
//   pop_i           : advance the head; caller guarantees non-empty
//   count_o         : number of queued entries (0..DEPTH)
//   head_data_o     : head instruction, read straight from the entry registers
//   head_pc_o       : head address (only with PREFETCH_PC_TAG_EN)
// Build option: `define PREFETCH_PC_TAG_EN adds an AW-bit PC field per entry.
// Push and pop in the same cycle are legal even when full.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = mcu_pkg::FIFO_DEPTH,
  parameter int DW    = mcu_pkg::INST_DW
`ifdef PREFETCH_PC_TAG_EN
  ,
  parameter int AW    = mcu_pkg::PROG_AW
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
`ifdef PREFETCH_PC_TAG_EN
  input  logic [AW-1:0]            push_pc_i,
  output logic [AW-1:0]            head_pc_o,
`endif
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DW-1:0]            head_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] data_q [DEPTH];
`ifdef PREFETCH_PC_TAG_EN
  logic [AW-1:0] pc_q   [DEPTH];
`endif
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the entry array is reset here only because the head output must
      // read 0 out of reset; a larger queue would gate the output instead.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
`ifdef PREFETCH_PC_TAG_EN
        pc_q[i]   <= '0;
`endif
      end
    end else if (flush_i) begin
      // Entry contents are left stale; count_o == 0 marks them invalid.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
`ifdef PREFETCH_PC_TAG_EN
        pc_q[wr_ptr_q]   <= push_pc_i;
`endif
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o     = count_q;
  assign head_data_o = data_q[rd_ptr_q];
`ifdef PREFETCH_PC_TAG_EN
  assign head_pc_o   = pc_q[rd_ptr_q];
`endif

endmodule

// File: rtl/inst_prefetch.sv
// -----------------------------------------------------------------------------
// inst_prefetch
// Instruction prefetch stage between the registered program ROM and the
// pipeline controller. Walks a fetch PC, issues one ROM read per cycle while
// queue slots are free, and queues returned instructions for the controller.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : inst_prefetch_if.master
//                prom_rd/prom_addr -> ROM, prom_data <- ROM (one cycle later)
//                ld pops the head; inst_valid/inst_out/inst_pc show the head
//                redirect/redirect_addr flush the queue and restart fetch
// Build option: `define PREFETCH_PC_TAG_EN to report the head address on
// inst_pc; otherwise inst_pc is tied to 0.
// -----------------------------------------------------------------------------
module inst_prefetch #(
  parameter int DEPTH = mcu_pkg::FIFO_DEPTH,
  parameter int AW    = mcu_pkg::PROG_AW,
  parameter int DW    = mcu_pkg::INST_DW
) (
  input  logic            clk,
  input  logic            reset,
  inst_prefetch_if.master bus
);

  import mcu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_e     state_q;
  logic [AW-1:0] fetch_pc_q;
  logic          inflight_q;   // a ROM read was issued last cycle
  logic          kill_q;       // response arriving this cycle belongs to a flushed stream

  logic [CW-1:0] count;
  logic [CW-1:0] occ;          // slots committed now: queued + in flight
  logic [CW-1:0] count_after;
  logic [CW-1:0] occ_next;     // slots committed after this edge
  logic          issue;
  logic          push;
  logic          pop;

  // A redirect cycle never issues, never accepts a response and never pops:
  // the flush at the edge overrides all three.
  assign issue = (state_q == FETCH) && (occ < CW'(DEPTH)) && !bus.redirect;
  assign push  = inflight_q && !kill_q && !bus.redirect;
  assign pop   = bus.ld && bus.inst_valid && !bus.redirect;

  // Slot accounting deliberately ignores a same-cycle pop when deciding to
  // issue; one queued entry plus one in flight still sustains a pop per cycle.
  // NOTE: every signal in this block is assigned on every pass, so no latch
  // can be inferred.
  always_comb begin
    occ         = count + CW'(inflight_q);
    count_after = count + CW'(push) - CW'(pop);
    occ_next    = count_after + CW'(issue);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      kill_q     <= bus.redirect;
      if (bus.redirect) begin
        state_q    <= FLUSH;
        fetch_pc_q <= bus.redirect_addr;
      end else begin
        // Wraps modulo 2^AW with no indication.
        if (issue) begin
          fetch_pc_q <= fetch_pc_q + AW'(1);
        end
        unique case (state_q)
          IDLE:    state_q <= FETCH;
          FETCH:   if (occ_next >= CW'(DEPTH)) state_q <= FULL;
          FULL:    if (occ_next <  CW'(DEPTH)) state_q <= FETCH;
          FLUSH:   state_q <= FETCH;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef PREFETCH_PC_TAG_EN
  // The in-flight read was issued from the previous fetch_pc; a redirect in
  // between would have killed the response, so fetch_pc - 1 is its address.
  logic [AW-1:0] push_pc;
  assign push_pc = fetch_pc_q - AW'(1);
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
`ifdef PREFETCH_PC_TAG_EN
    ,
    .AW    (AW)
`endif
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirect),
    .push_i      (push),
    .push_data_i (bus.prom_data),
`ifdef PREFETCH_PC_TAG_EN
    .push_pc_i   (push_pc),
    .head_pc_o   (bus.inst_pc),
`endif
    .pop_i       (pop),
    .count_o     (count),
    .head_data_o (bus.inst_out)
  );

  assign bus.prom_rd    = issue;
  assign bus.prom_addr  = fetch_pc_q;
  assign bus.inst_valid = (count != '0);
`ifndef PREFETCH_PC_TAG_EN
  assign bus.inst_pc    = '0;
`endif

endmodule
